// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/if_stage_pc_next.sv
// Combinational next-PC select: hold, sequential +4 or redirect target.
// Redirect targets are forced to a word boundary; misalign_o flags the raw target.
module pc_next
  import if_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            advance_i,
  output logic [XLEN-1:0] pc_nxt_o,
  output logic            misalign_o
);

  always_comb begin
    pc_nxt_o = pc_i;
    if (redirect_i) begin
      pc_nxt_o = {redirect_pc_i[XLEN-1:2], 2'b00};
    end else if (advance_i) begin
      pc_nxt_o = pc_i + PC_STEP;
    end
  end

  assign misalign_o = |redirect_pc_i[1:0];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem fetch, hold-until-accepted output.
// Optional misaligned-redirect trap enabled by defining IF_MISALIGN_TRAP_EN.
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        misalign_trap,
  output logic [31:0] trap_pc
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic            advance_c;
  logic            misalign_c;
  logic            trap_hit_c;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;

  pc_next u_pc_next (
    .pc_i          (pc_q),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .advance_i     (advance_c),
    .pc_nxt_o      (pc_d),
    .misalign_o    (misalign_c)
  );

`ifdef IF_MISALIGN_TRAP_EN
  logic            trap_q, trap_d;
  logic [XLEN-1:0] trap_pc_q, trap_pc_d;

  assign trap_hit_c = redirect && misalign_c && (state_q != HALT);

  always_comb begin
    trap_d    = trap_hit_c;
    trap_pc_d = trap_pc_q;
    if (trap_hit_c) trap_pc_d = redirect_pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      trap_q    <= 1'b0;
      trap_pc_q <= '0;
    end else begin
      trap_q    <= trap_d;
      trap_pc_q <= trap_pc_d;
    end
  end

  assign misalign_trap = trap_q;
  assign trap_pc       = trap_pc_q;
`else
  logic misalign_unused;
  assign misalign_unused = misalign_c;
  assign trap_hit_c      = 1'b0;
  assign misalign_trap   = 1'b0;
  assign trap_pc         = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= REQ;
      pc_q     <= RESET_PC;
      kill_q   <= 1'b0;
      instr_q  <= NOP_INSTR;
      valid_q  <= 1'b0;
      pc_out_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      kill_q   <= kill_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      pc_out_q <= pc_out_d;
    end
  end

  // Next state; kill marks the single outstanding fetch as stale after a redirect.
  always_comb begin
    state_d   = state_q;
    kill_d    = kill_q;
    advance_c = 1'b0;
    case (state_q)
      REQ: begin
        if (imem_gnt) begin
          state_d = WAIT;
          if (redirect) kill_d = 1'b1;
        end
      end
      WAIT: begin
        if (redirect) kill_d = 1'b1;
        if (imem_rvalid) begin
          if (kill_q || redirect) begin
            state_d = REQ;
            kill_d  = 1'b0;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          state_d = REQ;
        end else if (id_ready) begin
          state_d   = REQ;
          advance_c = 1'b1;
        end
      end
      HALT: state_d = HALT;
    endcase
    if (trap_hit_c) begin
      state_d = HALT;
      kill_d  = 1'b0;
    end
  end

  // Decode-facing output registers.
  always_comb begin
    instr_d  = instr_q;
    valid_d  = valid_q;
    pc_out_d = pc_out_q;
    if ((state_q == WAIT) && imem_rvalid && !kill_q && !redirect) begin
      instr_d  = imem_rdata;
      pc_out_d = pc_q;
      valid_d  = 1'b1;
    end
    if ((state_q == HOLD) && (redirect || id_ready)) valid_d = 1'b0;
    if (trap_hit_c) valid_d = 1'b0;
  end

  assign imem_req    = (state_q == REQ) && !reset;
  assign imem_addr   = pc_q;
  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc_out      = pc_out_q;
  assign pc_plus4    = pc_out_q + PC_STEP;

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage (honours IF_MISALIGN_TRAP_EN when defined).
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        misalign_trap;
  logic [31:0] trap_pc;

  int n_checks = 0;
  int n_fail   = 0;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .id_ready      (id_ready),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .pc_out        (pc_out),
    .pc_plus4      (pc_plus4),
    .misalign_trap (misalign_trap),
    .trap_pc       (trap_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One fetch: gnt in the REQ cycle, rvalid in the next, then check the held word.
  task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] p4);
    check({tag, "_req"}, 32'(imem_req), 32'd1);
    check({tag, "_addr"}, imem_addr, a);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    check({tag, "_wait_req"}, 32'(imem_req), 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = d;
    tick();
    imem_rvalid = 1'b0;
    check({tag, "_valid"}, 32'(instr_valid), 32'd1);
    check({tag, "_instr"}, instruction, d);
    check({tag, "_pc"}, pc_out, a);
    check({tag, "_p4"}, pc_plus4, p4);
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    tick();
    tick();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instruction, 32'h0000_0013);
    check("rst_pc", pc_out, 32'h0);
    check("rst_p4", pc_plus4, 32'h4);
    check("rst_trap", 32'(misalign_trap), 32'd0);
    check("rst_trap_pc", trap_pc, 32'h0);
    reset = 1'b0;
    #1;
    check("first_req", 32'(imem_req), 32'd1);

    // Back-to-back sequential fetch 0, 4, 8
    id_ready = 1'b1;
    fetch("seq0", 32'h0, 32'h1111_0001, 32'h4);
    tick();
    check("seq0_drop_valid", 32'(instr_valid), 32'd0);
    fetch("seq1", 32'h4, 32'h1111_0002, 32'h8);
    tick();
    fetch("seq2", 32'h8, 32'h1111_0003, 32'hC);

    // Decode back-pressure; a stray rvalid in HOLD is ignored
    id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin imem_rvalid = 1'b1; imem_rdata = 32'h5555_5555; end
      tick();
      imem_rvalid = 1'b0;
      check("bp_valid", 32'(instr_valid), 32'd1);
      check("bp_instr", instruction, 32'h1111_0003);
      check("bp_pc", pc_out, 32'h8);
      check("bp_req", 32'(imem_req), 32'd0);
    end
    id_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(instr_valid), 32'd0);
    fetch("seq3", 32'hC, 32'h1111_0004, 32'h10);

    // Redirect in WAIT; the late stale response must be discarded
    tick();
    check("wr_addr", imem_addr, 32'h10);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    check("wr_wait_req", 32'(imem_req), 32'd0);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    check("wr_stale_valid", 32'(instr_valid), 32'd0);
    check("wr_stale_instr", instruction, 32'h1111_0004);
    fetch("wr_tgt", 32'h100, 32'h2222_0001, 32'h104);

    // Redirect in HOLD without id_ready drops the held word
    id_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h20;
    tick();
    redirect = 1'b0;
    check("hr_drop_valid", 32'(instr_valid), 32'd0);
    fetch("hr_tgt", 32'h20, 32'h2222_0002, 32'h24);

    // Redirect together with id_ready beats the +4 update
    id_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    check("hr_prio_valid", 32'(instr_valid), 32'd0);
    fetch("hr_prio", 32'h40, 32'h2222_0003, 32'h44);

    // PC wrap at the top of the address space
    id_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    fetch("wrap", 32'hFFFF_FFFC, 32'h3333_0001, 32'h0);
    id_ready = 1'b1;
    tick();
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_req", 32'(imem_req), 32'd1);

    // Redirect in REQ, first without then with grant
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    check("rq_nogrant_addr", imem_addr, 32'h200);
    check("rq_nogrant_req", 32'(imem_req), 32'd1);
    redirect_pc = 32'h300; imem_gnt = 1'b1;
    tick();
    redirect = 1'b0; imem_gnt = 1'b0;
    check("rq_grant_req", 32'(imem_req), 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0001;
    tick();
    imem_rvalid = 1'b0;
    check("rq_grant_valid", 32'(instr_valid), 32'd0);
    check("rq_grant_instr", instruction, 32'h3333_0001);
    fetch("rq_tgt", 32'h300, 32'h4444_0001, 32'h304);

    // Misaligned redirect
    redirect = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
    check("mis_trap", 32'(misalign_trap), 32'd1);
    check("mis_trap_pc", trap_pc, 32'h102);
    check("mis_req", 32'(imem_req), 32'd0);
    check("mis_valid", 32'(instr_valid), 32'd0);
    tick();
    check("mis_pulse_end", 32'(misalign_trap), 32'd0);
    check("mis_trap_pc_hold", trap_pc, 32'h102);
    redirect = 1'b1; redirect_pc = 32'h500;
    tick();
    redirect = 1'b0;
    tick();
    check("mis_halt_req", 32'(imem_req), 32'd0);
    check("mis_halt_trap", 32'(misalign_trap), 32'd0);
`else
    check("mis_trap", 32'(misalign_trap), 32'd0);
    check("mis_trap_pc", trap_pc, 32'h0);
    fetch("mis_tgt", 32'h100, 32'h5555_0001, 32'h104);
`endif

    // Reset mid-operation
    reset = 1'b1;
    tick();
    check("rr_req", 32'(imem_req), 32'd0);
    check("rr_valid", 32'(instr_valid), 32'd0);
    check("rr_instr", instruction, 32'h0000_0013);
    check("rr_pc", pc_out, 32'h0);
    check("rr_trap_pc", trap_pc, 32'h0);
    reset = 1'b0;
    #1;
    fetch("rr_fetch", 32'h0, 32'h6666_0001, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
